// File: rtl/spi_flash_slave_os.sv
// Oversampling SPI flash target (mode 0). The SPI pins are sampled by the
// system clock, so no SPI signal is ever used as a clock. Commands handled:
// RDID 0x9F, READ 0x03, FAST_READ 0x0B and RDSR 0x05.
module spi_flash_slave_os #(
  parameter int          MEM_BYTES  = 256,
  parameter int          ADDR_BYTES = 3,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter int          DUMMY_CYC  = 8,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        cmd_unsupported,
  output logic [15:0] bytes_sent
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [5:0] ADDR_LAST  = 6'(8 * ADDR_BYTES - 1);
  localparam logic [5:0] DUMMY_LAST = (DUMMY_CYC > 0) ? 6'(DUMMY_CYC - 1) : 6'd0;
  localparam bit HAS_DUMMY = (DUMMY_CYC > 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_ID,
    SRC_STATUS
  } src_t;

  logic [1:0]    cs_sync;
  logic [1:0]    sck_sync;
  logic [1:0]    mosi_sync;
  logic          cs_prev;
  logic          sck_prev;
  logic          cs_s;
  logic          sck_s;
  logic          mosi_s;
  logic          cs_fall;
  logic          cs_rise;
  logic          rs;
  logic          fl;

  logic [7:0]    mem [MEM_BYTES];

  state_t        state;
  src_t          src;
  logic [5:0]    bit_cnt;
  logic [6:0]    shift_in;
  logic [AW-1:0] addr_sh;
  logic [AW-1:0] addr_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_inc;
  logic [1:0]    id_idx;
  logic [1:0]    id_next;
  logic [7:0]    tx_sh;
  logic [2:0]    tx_cnt;
  logic [7:0]    cmd_next;
  logic [7:0]    next_byte;

  // Two-flop synchronizers plus one history register for edge detection.
  // Chip select resets low so a frame already running at reset release
  // never produces a falling edge and is therefore ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= 2'b00;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_prev   <= cs_sync[1];
      sck_prev  <= sck_sync[1];
    end
  end

  assign cs_s    = cs_sync[1];
  assign sck_s   = sck_sync[1];
  assign mosi_s  = mosi_sync[1];
  assign cs_fall = ~cs_s & cs_prev;
  assign cs_rise = cs_s & ~cs_prev;
  assign rs      = sck_s & ~sck_prev;
  assign fl      = ~sck_s & sck_prev;

  assign cmd_next = {shift_in, mosi_s};
  assign ptr_inc  = ptr + AW'(1);
  assign id_next  = (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;

  // Only the low address bits are kept; upper address bits fall off the end.
  generate
    if (AW == 1) begin : g_addr_one
      assign addr_next = mosi_s;
    end else begin : g_addr_wide
      assign addr_next = {addr_sh[AW-2:0], mosi_s};
    end
  endgenerate

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      2'd2:    return JEDEC_ID[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Byte that follows the one currently being shifted out.
  always_comb begin
    next_byte = 8'h00;
    case (src)
      SRC_MEM:    next_byte = mem[ptr_inc];
      SRC_ID:     next_byte = id_byte(id_next);
      SRC_STATUS: next_byte = STATUS_VAL;
      default:    next_byte = 8'h00;
    endcase
  end

  // Read-only memory image, restored to an address ramp on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= 8'(i);
      end
    end
  end

  // Frame state machine: command, address and dummy bits are taken on SCK
  // rises, data bits are launched on SCK falls; a chip-select rise wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      src             <= SRC_MEM;
      bit_cnt         <= 6'd0;
      shift_in        <= 7'd0;
      addr_sh         <= '0;
      ptr             <= '0;
      id_idx          <= 2'd0;
      tx_sh           <= 8'h00;
      tx_cnt          <= 3'd0;
      spi_miso        <= 1'b0;
      spi_miso_oe     <= 1'b0;
      cmd_valid       <= 1'b0;
      cmd_code        <= 8'h00;
      cmd_unsupported <= 1'b0;
      bytes_sent      <= 16'h0000;
    end else begin
      cmd_valid       <= 1'b0;
      cmd_unsupported <= 1'b0;
      if (cs_rise) begin
        state       <= ST_IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (cs_fall) begin
        state       <= ST_CMD;
        bit_cnt     <= 6'd0;
        bytes_sent  <= 16'h0000;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (rs) begin
              shift_in <= cmd_next[6:0];
              bit_cnt  <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) begin
                bit_cnt   <= 6'd0;
                cmd_code  <= cmd_next;
                cmd_valid <= 1'b1;
                tx_cnt    <= 3'd0;
                case (cmd_next)
                  8'h9F: begin
                    state       <= ST_DATA;
                    src         <= SRC_ID;
                    id_idx      <= 2'd0;
                    tx_sh       <= JEDEC_ID[23:16];
                    spi_miso_oe <= 1'b1;
                  end
                  8'h05: begin
                    state       <= ST_DATA;
                    src         <= SRC_STATUS;
                    tx_sh       <= STATUS_VAL;
                    spi_miso_oe <= 1'b1;
                  end
                  8'h03, 8'h0B: begin
                    state   <= ST_ADDR;
                    addr_sh <= '0;
                  end
                  default: begin
                    state           <= ST_IGNORE;
                    cmd_unsupported <= 1'b1;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (rs) begin
              addr_sh <= addr_next;
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == ADDR_LAST) begin
                bit_cnt <= 6'd0;
                ptr     <= addr_next;
                if (cmd_code == 8'h0B && HAS_DUMMY) begin
                  state <= ST_DUMMY;
                end else begin
                  state       <= ST_DATA;
                  src         <= SRC_MEM;
                  tx_sh       <= mem[addr_next];
                  tx_cnt      <= 3'd0;
                  spi_miso_oe <= 1'b1;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (rs) begin
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == DUMMY_LAST) begin
                bit_cnt     <= 6'd0;
                state       <= ST_DATA;
                src         <= SRC_MEM;
                tx_sh       <= mem[ptr];
                tx_cnt      <= 3'd0;
                spi_miso_oe <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            spi_miso_oe <= 1'b1;
            if (fl) begin
              spi_miso <= tx_sh[7];
              if (tx_cnt == 3'd7) begin
                tx_cnt <= 3'd0;
                tx_sh  <= next_byte;
                ptr    <= ptr_inc;
                id_idx <= id_next;
                if (bytes_sent != 16'hFFFF) begin
                  bytes_sent <= bytes_sent + 16'd1;
                end
              end else begin
                tx_sh  <= {tx_sh[6:0], 1'b0};
                tx_cnt <= tx_cnt + 3'd1;
              end
            end
          end
          default: begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_slave_os.sv
// Self-checking bench for spi_flash_slave_os: a mode-0 SPI master drives
// frames and compares received bytes against a queue of expected bytes.
`timescale 1ns/1ps
module tb_spi_flash_slave_os;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        cmd_unsupported;
  logic [15:0] bytes_sent;

  int pass_cnt = 0;
  int check_cnt = 0;
  int valid_pulses = 0;
  int unsup_pulses = 0;
  int stray_unsup = 0;
  logic [7:0] exp_q[$];

  spi_flash_slave_os dut (
    .clk             (clk),
    .rst             (rst),
    .spi_cs_n        (spi_cs_n),
    .spi_sck         (spi_sck),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .spi_miso_oe     (spi_miso_oe),
    .cmd_valid       (cmd_valid),
    .cmd_code        (cmd_code),
    .cmd_unsupported (cmd_unsupported),
    .bytes_sent      (bytes_sent)
  );

  // Free-running system clock, 10 ns period.
  always #5 clk = ~clk;

  // Pulse counters for the command strobes, sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_valid) valid_pulses++;
    if (cmd_unsupported && cmd_valid) unsup_pulses++;
    if (cmd_unsupported && !cmd_valid) stray_unsup++;
  end

  // Overall time limit so the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Shifts nbits of tx out MSB first; returns bits sampled at each SCK rise
  // along with whether the output enable was ever / always high.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                           output logic oe_any, output logic oe_all);
    rx = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      rx = {rx[6:0], spi_miso};
      oe_any = oe_any | spi_miso_oe;
      oe_all = oe_all & spi_miso_oe;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt++;
    if ({spi_miso, spi_miso_oe, cmd_valid, cmd_unsupported} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b required 0000",
               {spi_miso, spi_miso_oe, cmd_valid, cmd_unsupported});
    else pass_cnt++;
    check_cnt++;
    if (cmd_code !== 8'h00) $display("[TB] FAIL reset_cmd_code: got %02h required 00", cmd_code);
    else pass_cnt++;
    check_cnt++;
    if (bytes_sent !== 16'h0000) $display("[TB] FAIL reset_bytes_sent: got %0d required 0", bytes_sent);
    else pass_cnt++;
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_rdid();
    logic [7:0] rx, exp;
    logic oa, ol;
    int v0;
    v0 = valid_pulses;
    frame_begin();
    xfer_bits(8'h9F, 8, rx, oa, ol);
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16); exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      xfer_bits(8'h00, 8, rx, oa, ol);
      exp = exp_q.pop_front();
      check_cnt++;
      if (rx !== exp) $display("[TB] FAIL rdid_byte%0d: got %02h required %02h", i, rx, exp);
      else pass_cnt++;
    end
    frame_end();
    check_cnt++;
    if (bytes_sent !== 16'd4) $display("[TB] FAIL rdid_bytes_sent: got %0d required 4", bytes_sent);
    else pass_cnt++;
    check_cnt++;
    if (valid_pulses - v0 !== 1) $display("[TB] FAIL rdid_valid_pulses: got %0d required 1", valid_pulses - v0);
    else pass_cnt++;
    check_cnt++;
    if (cmd_code !== 8'h9F) $display("[TB] FAIL rdid_cmd_code: got %02h required 9F", cmd_code);
    else pass_cnt++;
  endtask

  task automatic test_read_wrap();
    logic [7:0] rx, exp;
    logic oa, ol, hdr_oe;
    logic [7:0] hdr [4];
    hdr[0] = 8'h03; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'hFE;
    hdr_oe = 1'b0;
    frame_begin();
    check_cnt++;
    if (bytes_sent !== 16'd0) $display("[TB] FAIL read_bytes_sent_clear: got %0d required 0", bytes_sent);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      xfer_bits(hdr[i], 8, rx, oa, ol);
      hdr_oe = hdr_oe | oa;
    end
    check_cnt++;
    if (hdr_oe !== 1'b0) $display("[TB] FAIL read_oe_header: got %b required 0", hdr_oe);
    else pass_cnt++;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    for (int i = 0; i < 4; i++) begin
      xfer_bits(8'h00, 8, rx, oa, ol);
      exp = exp_q.pop_front();
      check_cnt++;
      if (rx !== exp || ol !== 1'b1)
        $display("[TB] FAIL read_byte%0d: got %02h oe_all %b required %02h oe_all 1", i, rx, ol, exp);
      else pass_cnt++;
    end
    frame_end();
    check_cnt++;
    if (spi_miso_oe !== 1'b0) $display("[TB] FAIL read_oe_after: got %b required 0", spi_miso_oe);
    else pass_cnt++;
  endtask

  task automatic test_fast_read();
    logic [7:0] rx, exp;
    logic oa, ol;
    logic [7:0] hdr [4];
    hdr[0] = 8'h0B; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h10;
    frame_begin();
    for (int i = 0; i < 4; i++) xfer_bits(hdr[i], 8, rx, oa, ol);
    xfer_bits(8'hA5, 8, rx, oa, ol);
    check_cnt++;
    if (rx !== 8'h00 || oa !== 1'b0)
      $display("[TB] FAIL fast_dummy: got miso %02h oe_any %b required 00 and 0", rx, oa);
    else pass_cnt++;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    for (int i = 0; i < 2; i++) begin
      xfer_bits(8'h00, 8, rx, oa, ol);
      exp = exp_q.pop_front();
      check_cnt++;
      if (rx !== exp) $display("[TB] FAIL fast_byte%0d: got %02h required %02h", i, rx, exp);
      else pass_cnt++;
    end
    frame_end();
    check_cnt++;
    if (bytes_sent !== 16'd2) $display("[TB] FAIL fast_bytes_sent: got %0d required 2", bytes_sent);
    else pass_cnt++;
  endtask

  task automatic test_unsupported();
    logic [7:0] rx;
    logic oa, ol, any_oe;
    logic [7:0] any_miso;
    int v0, u0;
    v0 = valid_pulses;
    u0 = unsup_pulses;
    any_oe = 1'b0;
    any_miso = 8'h00;
    frame_begin();
    xfer_bits(8'hAB, 8, rx, oa, ol);
    for (int i = 0; i < 2; i++) begin
      xfer_bits(8'hFF, 8, rx, oa, ol);
      any_oe = any_oe | oa;
      any_miso = any_miso | rx;
    end
    check_cnt++;
    if (any_miso !== 8'h00 || any_oe !== 1'b0)
      $display("[TB] FAIL unsup_outputs: got miso %02h oe %b required 00 and 0", any_miso, any_oe);
    else pass_cnt++;
    check_cnt++;
    if (cmd_code !== 8'hAB) $display("[TB] FAIL unsup_cmd_code: got %02h required AB", cmd_code);
    else pass_cnt++;
    frame_end();
    check_cnt++;
    if (unsup_pulses - u0 !== 1 || valid_pulses - v0 !== 1)
      $display("[TB] FAIL unsup_pulses: got unsup %0d valid %0d required 1 and 1",
               unsup_pulses - u0, valid_pulses - v0);
    else pass_cnt++;
  endtask

  task automatic test_abort_then_rdid();
    logic [7:0] rx, exp;
    logic oa, ol;
    int v0;
    v0 = valid_pulses;
    frame_begin();
    xfer_bits(8'h03, 8, rx, oa, ol);
    xfer_bits(8'h00, 8, rx, oa, ol);
    xfer_bits(8'h00, 4, rx, oa, ol);
    frame_end();
    frame_begin();
    check_cnt++;
    if (bytes_sent !== 16'd0) $display("[TB] FAIL abort_bytes_start: got %0d required 0", bytes_sent);
    else pass_cnt++;
    xfer_bits(8'h9F, 8, rx, oa, ol);
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16);
    for (int i = 0; i < 3; i++) begin
      xfer_bits(8'h00, 8, rx, oa, ol);
      exp = exp_q.pop_front();
      check_cnt++;
      if (rx !== exp) $display("[TB] FAIL abort_rdid_byte%0d: got %02h required %02h", i, rx, exp);
      else pass_cnt++;
    end
    xfer_bits(8'h00, 4, rx, oa, ol);
    frame_end();
    check_cnt++;
    if (bytes_sent !== 16'd3) $display("[TB] FAIL abort_partial_bytes: got %0d required 3", bytes_sent);
    else pass_cnt++;
    check_cnt++;
    if (valid_pulses - v0 !== 2) $display("[TB] FAIL abort_valid_pulses: got %0d required 2", valid_pulses - v0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx, exp;
    logic oa, ol;
    logic [7:0] hdr [4];
    hdr[0] = 8'h03; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00;
    frame_begin();
    for (int i = 0; i < 4; i++) xfer_bits(hdr[i], 8, rx, oa, ol);
    exp_q.push_back(8'h00);
    xfer_bits(8'h00, 8, rx, oa, ol);
    exp = exp_q.pop_front();
    check_cnt++;
    if (rx !== exp) $display("[TB] FAIL rstmid_byte0: got %02h required %02h", rx, exp);
    else pass_cnt++;
    xfer_bits(8'h00, 3, rx, oa, ol);
    check_cnt++;
    if (bytes_sent !== 16'd1 || spi_miso_oe !== 1'b1)
      $display("[TB] FAIL rstmid_before: got bytes %0d oe %b required 1 and 1", bytes_sent, spi_miso_oe);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({spi_miso, spi_miso_oe} !== 2'b00 || bytes_sent !== 16'd0)
      $display("[TB] FAIL rstmid_after: got miso %b oe %b bytes %0d required 0 0 0",
               spi_miso, spi_miso_oe, bytes_sent);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    xfer_bits(8'h9F, 8, rx, oa, ol);
    xfer_bits(8'h00, 8, rx, oa, ol);
    check_cnt++;
    if (oa !== 1'b0 || cmd_valid !== 1'b0 || valid_pulses < 0)
      $display("[TB] FAIL rstmid_ignored: got oe_any %b required 0", oa);
    else pass_cnt++;
    frame_end();
    hdr[3] = 8'h05;
    frame_begin();
    for (int i = 0; i < 4; i++) xfer_bits(hdr[i], 8, rx, oa, ol);
    exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    for (int i = 0; i < 2; i++) begin
      xfer_bits(8'h00, 8, rx, oa, ol);
      exp = exp_q.pop_front();
      check_cnt++;
      if (rx !== exp) $display("[TB] FAIL rstmid_read5_byte%0d: got %02h required %02h", i, rx, exp);
      else pass_cnt++;
    end
    frame_end();
  endtask

  task automatic test_strobes();
    check_cnt++;
    if (stray_unsup !== 0) $display("[TB] FAIL unsup_without_valid: got %0d required 0", stray_unsup);
    else pass_cnt++;
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] start");
    test_reset();
    test_rdid();
    test_read_wrap();
    test_fast_read();
    test_unsupported();
    test_abort_then_rdid();
    test_reset_mid_frame();
    test_strobes();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
